// File: rtl/mux16_arbiter_if.sv
// Handshake/bus bundle between the mux16 arbiter, its two requesters, the shared
// 16-bit two-input mux and the output consumer.
interface mux16_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             req0;
    logic [15:0]      data0;
    logic             req1;
    logic [15:0]      data1;
    logic             gnt0;
    logic             gnt1;
    logic             control;
    logic [15:0]      mux_result;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             out_src;
    logic             out_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    // Requesters, mux and consumer side.
    modport master (
        output req0, data0, req1, data1, mux_result, out_ready,
        input  gnt0, gnt1, control, out_valid, out_data, out_src, cnt0, cnt1
    );

    // Arbiter side.
    modport slave (
        input  req0, data0, req1, data1, mux_result, out_ready,
        output gnt0, gnt1, control, out_valid, out_data, out_src, cnt0, cnt1
    );
endinterface

// File: rtl/mux16_arbiter.sv
// Arbiter/sequencer for the shared 16-bit two-input mux with a one-entry output register.
// Define MUX16_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module mux16_arbiter #(
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             reset,
    mux16_arbiter_if.slave  bus
);
    logic        control_reg;
    logic        out_valid_reg;
    logic [15:0] out_data_reg;
    logic        out_src_reg;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        sel;
    logic        take;
    logic        grant;
    logic        contend_sel;

`ifdef MUX16_ARB_RR_EN
    logic last_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (grant) begin
            last_reg <= sel;
        end
    end

    assign contend_sel = ~last_reg;
`else
    assign contend_sel = 1'b0;
`endif

    assign req = {bus.req1, bus.req0};

    // With no request the select holds, so the mux does not toggle needlessly.
    always_comb begin
        sel = control_reg;
        case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = contend_sel;
            default: sel = control_reg;
        endcase
        take  = !out_valid_reg || bus.out_ready;
        grant = !reset && take && (req != 2'b00);
        gnt   = 2'b00;
        if (grant) begin
            gnt[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            control_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 16'h0000;
            out_src_reg   <= 1'b0;
        end else begin
            control_reg <= sel;
            if (grant) begin
                out_data_reg  <= bus.mux_result;
                out_src_reg   <= sel;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (gnt[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.control   = sel;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_src   = out_src_reg;
    assign bus.cnt0      = g_cnt[0].cnt_reg;
    assign bus.cnt1      = g_cnt[1].cnt_reg;
endmodule

// File: tb/tb_mux16_arbiter.sv
// Randomized bench for mux16_arbiter against a transaction-level reference model.
module tb_mux16_arbiter;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MUX16_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux16_arbiter_if #(.CNT_W(CNT_W)) bus ();

    // The shared mux itself is purely combinational.
    assign bus.mux_result = bus.control ? bus.data1 : bus.data0;

    mux16_arbiter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: output slot contents, held select, last winner, grant tallies.
    bit          m_valid;
    logic [15:0] m_data;
    bit          m_src;
    int          m_ctrl;
    int          m_last;
    int          m_cnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = 16'h0000;
        m_src    = 1'b0;
        m_ctrl   = 0;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic cycle(input bit rst, input bit r0, input logic [15:0] d0,
                         input bit r1, input logic [15:0] d1, input bit rdy);
        int win;
        bit granted;
        reset         = rst;
        bus.req0      = r0;
        bus.data0     = d0;
        bus.req1      = r1;
        bus.data1     = d1;
        bus.out_ready = rdy;
        #1;
        if (r0 && r1)  win = RR ? (m_last + 1) % 2 : 0;
        else if (r0)   win = 0;
        else if (r1)   win = 1;
        else           win = m_ctrl;
        granted = !rst && (!m_valid || rdy) && (r0 || r1);
        check("gnt0",      bus.gnt0,      granted && (win == 0));
        check("gnt1",      bus.gnt1,      granted && (win == 1));
        check("control",   bus.control,   win);
        check("out_valid", bus.out_valid, m_valid);
        check("out_data",  bus.out_data,  m_data);
        check("out_src",   bus.out_src,   m_src);
        check("cnt0",      bus.cnt0,      m_cnt[0]);
        check("cnt1",      bus.cnt1,      m_cnt[1]);
        @(posedge clk);
        #1;
        if (!rst && m_valid && rdy)
            $display("txn: consumed src=%0d data=%h", m_src, m_data);
        if (rst) begin
            model_reset();
        end else begin
            if (granted) begin
                m_data  = (win == 1) ? d1 : d0;
                m_src   = win[0];
                m_valid = 1'b1;
                m_last  = win;
                if (m_cnt[win] < CNT_MAX) m_cnt[win]++;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            m_ctrl = win;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req0      = 1'b1;
        bus.req1      = 1'b1;
        bus.data0     = 16'h0000;
        bus.data1     = 16'h0000;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with both requests high: no grants, clean state.
        cycle(1'b1, 1'b1, 16'h5678, 1'b1, 16'h1234, 1'b1);
        cycle(1'b1, 1'b1, 16'h5678, 1'b1, 16'h1234, 1'b1);

        // Single requester, then its word appears next cycle.
        cycle(1'b0, 1'b1, 16'h5678, 1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Contention with the consumer always ready.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 16'h5678, 1'b1, 16'h1234, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Backpressure: slot full, consumer stalled, requester 1 waiting.
        cycle(1'b0, 1'b1, 16'h00aa, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Counter saturation from a fresh reset.
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, 16'(i + 16'h100), 1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Random traffic with occasional mid-run resets.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 49) == 0, 1'($urandom), 16'($urandom),
                  1'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
